// File: rtl/param_ctrl_gen_if.sv
// Front-panel bus for param_ctrl_gen: key pulses in, parameter values and
// display data out. The master side is the panel/display logic and the slave
// side is the controller. With HOLD_REPEAT_EN defined, the bus also carries
// the inc_hold/dec_hold level inputs.
interface param_ctrl_gen_if #(
   parameter int NUM_CH = 5,
   parameter int W      = 11,
   parameter int DIGITS = 4
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                  key_sel;
   logic                  key_inc;
   logic                  key_dec;
`ifdef HOLD_REPEAT_EN
   logic                  inc_hold;
   logic                  dec_hold;
`endif
   logic [NUM_CH*W-1:0]   param_bus;
   logic [CH_W-1:0]       ch_sel;
   logic                  changed;
   logic [DIGITS*4-1:0]   disp_bcd;
   logic [CH_W-1:0]       disp_ch;
   logic                  disp_valid;
   logic                  busy;

   modport master (
`ifdef HOLD_REPEAT_EN
      output inc_hold, dec_hold,
`endif
      output key_sel, key_inc, key_dec,
      input  param_bus, ch_sel, changed, disp_bcd, disp_ch, disp_valid, busy
   );

   modport slave (
`ifdef HOLD_REPEAT_EN
      input  inc_hold, dec_hold,
`endif
      input  key_sel, key_inc, key_dec,
      output param_bus, ch_sel, changed, disp_bcd, disp_ch, disp_valid, busy
   );
endinterface

// File: rtl/param_ctrl_gen.sv
// Key-driven parameter controller for the signal-generator front panel.
// Holds NUM_CH parameters with per-channel min/max/step/init and wrap or
// saturate policy. key_sel rotates the active channel; key_inc/key_dec adjust
// it. Every change (and the first clock after reset) launches a sequential
// double-dabble conversion of the active value into packed BCD for the
// seven-segment driver; a newer change restarts a conversion in flight.
// Optional feature macro HOLD_REPEAT_EN: adds inc_hold/dec_hold level inputs
// with an auto-repeat timer (HOLD_DLY initial delay, then REPEAT_PER period).
module param_ctrl_gen #(
   parameter int                  NUM_CH   = 5,
   parameter int                  W        = 11,
   parameter int                  DIGITS   = 4,
   parameter logic [NUM_CH*W-1:0] MIN_VEC  = {11'd2, 11'd10, 11'd10, 11'd1, 11'd1},
   parameter logic [NUM_CH*W-1:0] MAX_VEC  = {11'd20, 11'd800, 11'd300, 11'd4, 11'd6},
   parameter logic [NUM_CH*W-1:0] STEP_VEC = {11'd1, 11'd10, 11'd10, 11'd1, 11'd1},
   parameter logic [NUM_CH*W-1:0] INIT_VEC = MIN_VEC,
   parameter logic [NUM_CH-1:0]   WRAP_MSK = 5'b11111
`ifdef HOLD_REPEAT_EN
   ,
   parameter int                  HOLD_DLY   = 25_000_000,
   parameter int                  REPEAT_PER = 5_000_000
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   param_ctrl_gen_if.slave   bus
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(W + 1);
   localparam int BCD_W = DIGITS * 4;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

   // Increment with W+1-bit headroom so v+step cannot alias past max.
   function automatic logic [W-1:0] step_up(input logic [W-1:0] v,
                                            input logic [W-1:0] lo,
                                            input logic [W-1:0] hi,
                                            input logic [W-1:0] st,
                                            input logic         wrap);
      logic [W:0] sum;
      sum = {1'b0, v} + {1'b0, st};
      if (sum > {1'b0, hi})
         return wrap ? lo : hi;
      return sum[W-1:0];
   endfunction

   // Decrement; the bound test is v < min+step so v-step never underflows.
   function automatic logic [W-1:0] step_dn(input logic [W-1:0] v,
                                            input logic [W-1:0] lo,
                                            input logic [W-1:0] hi,
                                            input logic [W-1:0] st,
                                            input logic         wrap);
      if ({1'b0, v} < ({1'b0, lo} + {1'b0, st}))
         return wrap ? hi : lo;
      return v - st;
   endfunction

   // Double-dabble correction: any BCD digit of 5 or more gets +3 before shifting.
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] acc);
      logic [BCD_W-1:0] r;
      r = acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc[d*4 +: 4] >= 4'd5)
            r[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   logic [W-1:0]        param_q [NUM_CH];
   logic [W-1:0]        param_d [NUM_CH];
   logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
   logic                changed_q, changed_d;
   logic                start_q, start_d;
   logic                inc_req, dec_req;
   logic                inc_ev, dec_ev;
   logic                val_chg;
   logic [W-1:0]        act_val;
   logic                conv_start;
   logic [NUM_CH*W-1:0] bus_pack;

   conv_state_t         state_q;
   logic [W-1:0]        bin_q;
   logic [BCD_W-1:0]    acc_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CH_W-1:0]     snap_ch_q;
   logic [BCD_W-1:0]    disp_bcd_q;
   logic [CH_W-1:0]     disp_ch_q;
   logic                disp_valid_q;
   logic                busy_q;

`ifdef HOLD_REPEAT_EN
   localparam int HOLD_MAX = (HOLD_DLY > REPEAT_PER) ? HOLD_DLY : REPEAT_PER;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              hold_rep_q, hold_rep_d;
   logic              hold_one;
   logic              hold_fire;

   // Hold timer: first event after HOLD_DLY held cycles, then every REPEAT_PER.
   always_comb begin
      hold_one   = bus.inc_hold ^ bus.dec_hold;
      hold_fire  = 1'b0;
      hold_cnt_d = '0;
      hold_rep_d = 1'b0;
      if (hold_one) begin
         hold_rep_d = hold_rep_q;
         hold_cnt_d = hold_cnt_q + 1'b1;
         if (hold_cnt_q == HOLD_W'(hold_rep_q ? (REPEAT_PER - 1) : (HOLD_DLY - 1))) begin
            hold_fire  = 1'b1;
            hold_cnt_d = '0;
            hold_rep_d = 1'b1;
         end
      end
   end

   // Hold timer registers; releasing both holds clears them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt_q <= '0;
         hold_rep_q <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         hold_rep_q <= hold_rep_d;
      end
   end

   // A key pulse coinciding with a generated event still counts once.
   assign inc_req = bus.key_inc | (hold_fire & bus.inc_hold);
   assign dec_req = bus.key_dec | (hold_fire & bus.dec_hold);
`else
   assign inc_req = bus.key_inc;
   assign dec_req = bus.key_dec;
`endif

   // Simultaneous inc and dec cancel each other.
   assign inc_ev = inc_req & ~dec_req;
   assign dec_ev = dec_req & ~inc_req;

   // Next parameter values, channel selection and change detection.
   always_comb begin
      val_chg  = 1'b0;
      act_val  = '0;
      start_d  = 1'b0;
      ch_sel_d = ch_sel_q;
      for (int i = 0; i < NUM_CH; i++) begin
         param_d[i] = param_q[i];
         if (ch_sel_q == CH_W'(i)) begin
            act_val = param_q[i];
            if (inc_ev)
               param_d[i] = step_up(param_q[i], MIN_VEC[i*W +: W], MAX_VEC[i*W +: W],
                                    STEP_VEC[i*W +: W], WRAP_MSK[i]);
            else if (dec_ev)
               param_d[i] = step_dn(param_q[i], MIN_VEC[i*W +: W], MAX_VEC[i*W +: W],
                                    STEP_VEC[i*W +: W], WRAP_MSK[i]);
         end
         if (param_d[i] != param_q[i])
            val_chg = 1'b1;
      end
      if (bus.key_sel)
         ch_sel_d = (ch_sel_q == LAST_CH) ? '0 : ch_sel_q + 1'b1;
      changed_d = val_chg | bus.key_sel;
   end

   // Parameter, selection and change-pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++)
            param_q[i] <= INIT_VEC[i*W +: W];
         ch_sel_q  <= '0;
         changed_q <= 1'b0;
         start_q   <= 1'b1;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            param_q[i] <= param_d[i];
         ch_sel_q  <= ch_sel_d;
         changed_q <= changed_d;
         start_q   <= start_d;
      end
   end

   // start_q is set only for the first clock after reset, giving the auto-start.
   assign conv_start = changed_d | start_q;

   // Converter FSM; a new change from any state (re)enters LOAD on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         bin_q        <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         snap_ch_q    <= '0;
         disp_bcd_q   <= '0;
         disp_ch_q    <= '0;
         disp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         disp_valid_q <= 1'b0;
         if (conv_start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
         end else begin
            case (state_q)
               LOAD: begin
                  bin_q     <= act_val;
                  snap_ch_q <= ch_sel_q;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  state_q   <= SHIFT;
               end
               SHIFT: begin
                  {acc_q, bin_q} <= {dd_adjust(acc_q), bin_q} << 1;
                  cnt_q          <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(W - 1))
                     state_q <= DONE;
               end
               DONE: begin
                  disp_bcd_q   <= acc_q;
                  disp_ch_q    <= snap_ch_q;
                  disp_valid_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   // Flatten the channel registers onto the output bus, channel 0 at the LSBs.
   always_comb begin
      bus_pack = '0;
      for (int i = 0; i < NUM_CH; i++)
         bus_pack[i*W +: W] = param_q[i];
   end

   assign bus.param_bus  = bus_pack;
   assign bus.ch_sel     = ch_sel_q;
   assign bus.changed    = changed_q;
   assign bus.disp_bcd   = disp_bcd_q;
   assign bus.disp_ch    = disp_ch_q;
   assign bus.disp_valid = disp_valid_q;
   assign bus.busy       = busy_q;

endmodule
